// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Optional addi support is compiled in with MULTICYCLE_ADDI_EN.
package mips_ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU B-input select codes
  localparam logic [1:0] ASB_REGB   = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  // PC source select codes
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Main control states; encodings are visible on dbg_state.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // True when DECODE has somewhere to send this opcode.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Combinational Moore output decoder: state (+ mem_ready for the fetch
// write enables) to every datapath control. Reset forces all outputs low so
// no write enable survives into the cycle reset rises.
// Optional addi states are decoded only with MULTICYCLE_ADDI_EN.
module multicycle_control_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_op0,
  output logic       alu_op1,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source
);

  // Per-state control decode; everything defaults to 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_op0       = 1'b0;
    alu_op1       = 1'b0;
    alu_src_b     = ASB_REGB;
    pc_source     = PCS_ALU;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          // PC/IR only capture once memory has delivered the instruction.
          mem_read  = 1'b1;
          alu_src_b = ASB_FOUR;
          pc_source = PCS_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = ASB_IMM_SH;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_REGB;
          alu_op1   = 1'b1;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = ASB_REGB;
          alu_op0       = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and
// next-state logic; outputs come from multicycle_control_outdec.
// Handshake: mem_ready=1 in a cycle where MemRead/MemWrite is asserted means
// memory completed that access this cycle; the FSM holds in FETCH, MEMRD or
// MEMWR until it sees mem_ready=1, and never advances PC/IR before then.
// Define MULTICYCLE_ADDI_EN to add the addi path (ADDIEX -> ADDIWB).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUOP0,
  output logic               ALUOP1,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  state_t state_q;
  state_t state_d;

  // State register, asynchronously forced to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state: memory states wait on mem_ready, DECODE/MEMADR use opcode.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      // MEMWB, RWB, BRANCH, JUMP, ADDIWB and unused encodings
      default:  state_d = S_FETCH;
    endcase
  end

  // Unsupported opcode flag, only meaningful while decoding.
  always_comb begin
    illegal_op = !reset && (state_q == S_DECODE) && !op_supported(opcode);
  end

  assign dbg_state = STATE_W'(state_q);

  multicycle_control_outdec u_outdec (
    .rst           (reset),
    .state         (state_q),
    .mem_ready     (mem_ready),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .i_or_d        (IorD),
    .mem_read      (MemRead),
    .mem_write     (MemWrite),
    .mem_to_reg    (MemtoReg),
    .ir_write      (IRWrite),
    .alu_src_a     (ALUSrcA),
    .reg_write     (RegWrite),
    .reg_dst       (RegDst),
    .alu_op0       (ALUOP0),
    .alu_op1       (ALUOP1),
    .alu_src_b     (ALUSrcB),
    .pc_source     (PCSource)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction (with chosen stall counts) into its expected per-cycle control
// trace; a driver replays the inputs and a monitor checks every cycle.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam int W = 21;

  typedef struct packed {
    logic [3:0] st;
    logic ill, pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, a1, a0;
    logic [1:0] asb, pcs;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    ctl_t       exp;
  } step_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic ALUSrcA, RegWrite, RegDst, ALUOP0, ALUOP1, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUOP0(ALUOP0), .ALUOP1(ALUOP1), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {dbg_state, illegal_op, PCWrite, PCWriteCond, IorD, MemRead,
                    MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
                    ALUOP1, ALUOP0, ALUSrcB, PCSource};

  // ---------------- scoreboard state ----------------
  step_t        plan[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [5:0] op);
`ifdef MULTICYCLE_ADDI_EN
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
`else
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
`endif
  endfunction

  task automatic add(input logic [5:0] op, input logic rdy, input ctl_t c);
    step_t s;
    s.op = op; s.rdy = rdy; s.exp = c;
    plan.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle-by-cycle trace.
  task automatic build_instr(input logic [5:0] op, input int fstall, input int mstall);
    ctl_t c;
    // fetch: memory read of PC, PC+4 computed; commit only when ready
    for (int i = 0; i < fstall; i++) begin
      c = '0; c.st = 4'd0; c.mr = 1'b1; c.asb = 2'b01;
      add(6'($urandom_range(0, 63)), 1'b0, c);
    end
    c = '0; c.st = 4'd0; c.mr = 1'b1; c.asb = 2'b01; c.pcw = 1'b1; c.irw = 1'b1;
    add(6'($urandom_range(0, 63)), 1'b1, c);
    // decode: branch target precomputed
    c = '0; c.st = 4'd1; c.asb = 2'b11; c.ill = !is_legal(op);
    add(op, rnd_bit(), c);
    if (!is_legal(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      c = '0; c.st = 4'd2; c.asa = 1'b1; c.asb = 2'b10;
      add(op, rnd_bit(), c);
      for (int i = 0; i <= mstall; i++) begin
        c = '0; c.iord = 1'b1;
        if (op == OP_LW) begin c.st = 4'd3; c.mr = 1'b1; end
        else begin c.st = 4'd5; c.mw = 1'b1; end
        add(op, (i == mstall), c);
      end
      if (op == OP_LW) begin
        c = '0; c.st = 4'd4; c.rw = 1'b1; c.m2r = 1'b1;
        add(op, rnd_bit(), c);
      end
    end else if (op == OP_RTYPE) begin
      c = '0; c.st = 4'd6; c.asa = 1'b1; c.a1 = 1'b1;
      add(op, rnd_bit(), c);
      c = '0; c.st = 4'd7; c.rw = 1'b1; c.rd = 1'b1;
      add(op, rnd_bit(), c);
    end else if (op == OP_BEQ) begin
      c = '0; c.st = 4'd8; c.asa = 1'b1; c.a0 = 1'b1; c.pcwc = 1'b1; c.pcs = 2'b01;
      add(op, rnd_bit(), c);
    end else if (op == OP_J) begin
      c = '0; c.st = 4'd9; c.pcw = 1'b1; c.pcs = 2'b10;
      add(op, rnd_bit(), c);
    end else begin
      c = '0; c.st = 4'd10; c.asa = 1'b1; c.asb = 2'b10;
      add(op, rnd_bit(), c);
      c = '0; c.st = 4'd11; c.rw = 1'b1;
      add(op, rnd_bit(), c);
    end
  endtask

  task automatic build_random(input int n);
    logic [5:0] op;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 6))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op) || op == OP_ADDI) op = 6'($urandom_range(0, 63));
        end
      endcase
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  // ---------------- driver ----------------
  // Applies one planned step per cycle just after the edge; when idle it
  // holds mem_ready low so the FSM waits in place.
  initial begin
    step_t s;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && plan.size() > 0) begin
        s = plan.pop_front();
        opcode = s.op;
        mem_ready = s.rdy;
        exp_q.push_back(W'(s.exp));
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 cyc, dut_vec[W-1 -: 4], dut_vec[W-5:0], e[W-1 -: 4], e[W-5:0]);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((plan.size() > 0 || exp_q.size() > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: %0d steps still pending, required 0",
               plan.size() + exp_q.size());
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // outputs must be low during reset even with FETCH conditions present
    repeat (3) @(negedge clk);
    check_vec("reset_outputs", dut_vec, '0);
    // directed instructions
    build_instr(OP_RTYPE, 0, 0);
    build_instr(OP_LW, 0, 2);
    build_instr(OP_RTYPE, 3, 0);
    build_instr(OP_BEQ, 0, 0);
    build_instr(OP_J, 0, 0);
    build_instr(6'b111111, 0, 0);
    build_instr(OP_SW, 0, 0);
    build_instr(OP_ADDI, 0, 0);
    build_instr(OP_SW, 1, 3);
    reset = 1'b0;
    drain();
    // random instruction stream
    build_random(40);
    drain();
    // park in MEMWR, then reset asynchronously mid-cycle
    build_instr(OP_SW, 0, 4);
    while (plan.size() > 4) void'(plan.pop_back());
    drain();
    @(negedge clk);
    check_vec("memwr_parked_state", W'(dbg_state), W'(4'd5));
    #2;
    reset = 1'b1;
    #1;
    check_vec("async_reset_outputs", dut_vec, '0);
    @(negedge clk);
    check_vec("reset_held_outputs", dut_vec, '0);
    @(negedge clk);
    reset = 1'b0;
    // execution resumes cleanly from FETCH
    build_instr(OP_RTYPE, 0, 0);
    build_random(15);
    drain();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and write-back.
- Drives the ALUOP0/ALUOP1 pair consumed by alu_control, plus all datapath mux and enable signals.
- Adds a memory-ready stall handshake so fetch and data accesses hold until memory responds.

Parameters:
- STATE_W, 4, width of the state register and of the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current MemRead/MemWrite this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite  out  1 each  datapath controls.
- ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- ALUOP0, ALUOP1  out  1 each  to alu_control.
- ALUSrcB  out  2  ALU B-input select: 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- dbg_state  out  STATE_W  current state encoding.

Behaviour:
- Reset: clk is the only clock; reset is asynchronous, active-high.
  - While reset is high: state=FETCH, all outputs 0, dbg_state=0.
  - The first FETCH outputs appear in the cycle after reset is released.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12-15 go to FETCH on the next edge.
- Per-state outputs; any output not listed is 0:
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite = mem_ready. Stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1. PC and IR must never update during a stall.
  - DECODE: ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if opcode=lw, else MEMWR.
  - MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
  - MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP1=1, ALUOP0=0. Then RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP0=1, ALUOP1=0, PCWriteCond=1, PCSource=01. Then FETCH.
  - JUMP: PCWrite=1, PCSource=10. Then FETCH.
- Opcode sampling: opcode is only meaningful from DECODE onward and is sampled in DECODE and MEMADR. The IR holds it stable because IRWrite=0 outside FETCH.
- Instruction latency, in cycles with no stalls: R-type 4, lw 5, sw 4, beq 3, j 3. Each stall cycle in FETCH, MEMRD or MEMWR adds exactly 1.
- Reset mid-instruction: aborts immediately. No write-enable may remain asserted in the cycle reset rises.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined: opcode 001000 (addi) goes from DECODE to ADDIEX, then ADDIWB, then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - addi latency is 4 cycles.
- Undefined: 001000 is illegal (illegal_op pulse, back to FETCH). Encodings 10 and 11 are unreachable and handled like 12-15.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state_t enum (4-bit, encodings above)
  - ALUSrcB and PCSource code constants
- One natural sub-module: multicycle_control_outdec, a purely combinational decoder from state and mem_ready to all control outputs.
- The top module holds the state register and next-state logic only.

Test Plan:
- Reset then R-type:
  - Stimulus: reset 1->0, opcode=000000, mem_ready=1.
  - Response: dbg_state 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOP1=1 only in state 6.
- lw with 2-cycle stall:
  - Stimulus: opcode=100011, mem_ready=0 for the first 2 MEMRD cycles.
  - Response: states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 across all three MEMRD cycles; RegWrite=1 only in state 4.
- Fetch stall:
  - Stimulus: mem_ready=0 for 3 cycles in FETCH.
  - Response: PCWrite=0 and IRWrite=0 for those 3 cycles; both 1 in the 4th cycle; then state 1.
- beq and j:
  - beq (000100): states 0,1,8,0; PCWriteCond=1, PCSource=01, ALUOP0=1 in state 8.
  - j (000010): states 0,1,9,0; PCWrite=1, PCSource=10 in state 9.
- Illegal opcode and sw:
  - Stimulus: opcode=111111.
  - Response: illegal_op=1 for exactly one cycle in state 1, then state 0, with no write enables asserted.
  - Also with opcode=101011 (sw): states 0,1,2,5,0 with MemWrite=1 only in state 5.
- Mid-instruction reset:
  - Stimulus: assert reset asynchronously while in MEMWR.
  - Response: all outputs 0 before the next clk edge; dbg_state=0.
  - With MULTICYCLE_ADDI_EN defined, addi gives states 0,1,10,11,0.
